timing_gen: RTL and testbench

- Generates the 4004 two-phase clocks (clk1, clk2) from the 50 MHz sysclk.
- Runs the 8-subcycle instruction-cycle sequencer: A1 A2 A3 M1 M2 X1 X2 X3.
- Decodes the subcycle/phase timing strobes consumed by the scratchpad, ALU, instruction-decode and I/O blocks (a12, a22, a32, m12, m22, x12, x22, x32, m12_m22_clk1_m11_m12, sync).
- Sits directly upstream of the scratchpad register array and drives its timing inputs.

---
 rtl/timing_gen.sv | 103 ++++++++++
 tb/tb_timing_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/timing_gen.sv
// timing_gen: 4004 two-phase clock, subcycle sequencer and timing strobes; define TIMING_SINGLE_STEP_EN for step_mode/step stall control
module timing_gen #(
    parameter int PHASE_LEN = 17
) (
    input  logic       sysclk,
    input  logic       poc_n,
`ifdef TIMING_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    output logic       clk1,
    output logic       clk2,
    output logic [2:0] subcycle,
    output logic       a12,
    output logic       a22,
    output logic       a32,
    output logic       m12,
    output logic       m22,
    output logic       x12,
    output logic       x22,
    output logic       x32,
    output logic       m12_m22_clk1_m11_m12,
    output logic       sync
);
    localparam logic [7:0] LAST = 8'(PHASE_LEN - 1);

    if (PHASE_LEN < 2 || PHASE_LEN > 255) begin : g_bad_len
        $error("timing_gen: PHASE_LEN must be in 2..255");
    end

    logic       run, armed, last, stall, n_armed, m11_n;
    logic [7:0] pcnt, n_pcnt, st, st_n;
    logic [1:0] slot, n_slot;
    logic [2:0] sub, n_sub, idx, idx1;

    assign last = pcnt == LAST;

`ifdef TIMING_SINGLE_STEP_EN
    logic [2:0] step_sync;
    logic       go, at_end;
    assign at_end = run && sub == 3'd7 && slot == 2'd3 && last;
    assign stall  = at_end && step_mode && !go;
    // Synchronise step, detect its rising edge, and arm one release only while stalled
    always_ff @(posedge sysclk or negedge poc_n)
        if (!poc_n) begin
            step_sync <= '0;
            go        <= 1'b0;
        end else begin
            step_sync <= {step_sync[1:0], step};
            go        <= stall && step_sync[1] && !step_sync[2];
        end
`else
    assign stall = 1'b0;
`endif

    // Next sequencer state and the strobes it implies; outputs are registered from these
    always_comb begin
        n_pcnt  = !run ? 8'd0 : stall ? pcnt : last ? 8'd0 : pcnt + 8'd1;
        n_slot  = !run ? 2'd0 : stall ? slot : slot + 2'(last);
        n_sub   = !run ? 3'd0 : stall ? sub : sub + 3'(last && slot == 2'd3);
        n_armed = armed || n_slot == 2'd2;
        idx     = n_slot[1] ? n_sub : n_sub - 3'd1;
        idx1    = n_slot != 2'd0 ? n_sub : n_sub - 3'd1;
        st_n    = n_armed ? 8'd1 << idx : 8'd0;
        // m11 starts as M1's clk1 pulse ends, so that pulse itself passes the clk1 term
        m11_n   = idx1 == 3'd3;
    end

    // Sequencer counters; the first edge after reset enters A1 slot 0
    always_ff @(posedge sysclk or negedge poc_n)
        if (!poc_n) begin
            run   <= 1'b0;
            armed <= 1'b0;
            pcnt  <= '0;
            slot  <= '0;
            sub   <= '0;
        end else begin
            run   <= 1'b1;
            armed <= n_armed;
            pcnt  <= n_pcnt;
            slot  <= n_slot;
            sub   <= n_sub;
        end

    // Registered clocks and strobes, changing on the same edge as their governing state
    always_ff @(posedge sysclk or negedge poc_n)
        if (!poc_n) begin
            clk1                 <= 1'b0;
            clk2                 <= 1'b0;
            st                   <= '0;
            sync                 <= 1'b0;
            m12_m22_clk1_m11_m12 <= 1'b0;
        end else begin
            clk1                 <= n_slot == 2'd0;
            clk2                 <= n_slot == 2'd2;
            st                   <= st_n;
            sync                 <= n_sub == 3'd7;
            m12_m22_clk1_m11_m12 <= st_n[3] || st_n[4] || (n_slot == 2'd0 && !(m11_n || st_n[3]));
        end

    assign subcycle = sub;
    assign {x32, x22, x12, m22, m12, a32, a22, a12} = st;
endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: checks timing_gen at PHASE_LEN 2 and 17 against an arithmetic model of the cycle timeline
module tb_timing_gen;
    logic sysclk = 1'b0;
    logic poc_n = 1'b0;
`ifdef TIMING_SINGLE_STEP_EN
    logic step_mode = 1'b0;
    logic step = 1'b0;
`endif
    wire       clk1_a, clk2_a, comp_a, sync_a, clk1_b, clk2_b, comp_b, sync_b;
    wire [2:0] sub_a, sub_b;
    wire [7:0] st_a, st_b;
    wire [14:0] v2  = {clk1_a, clk2_a, sub_a, st_a, comp_a, sync_a};
    wire [14:0] v17 = {clk1_b, clk2_b, sub_b, st_b, comp_b, sync_b};
    int cmp = 0;
    int errs = 0;
    int k = 0;

    always #10 sysclk = ~sysclk;

    timing_gen #(.PHASE_LEN(2)) u2 (
        .sysclk(sysclk), .poc_n(poc_n),
`ifdef TIMING_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .clk1(clk1_a), .clk2(clk2_a), .subcycle(sub_a),
        .a12(st_a[0]), .a22(st_a[1]), .a32(st_a[2]), .m12(st_a[3]),
        .m22(st_a[4]), .x12(st_a[5]), .x22(st_a[6]), .x32(st_a[7]),
        .m12_m22_clk1_m11_m12(comp_a), .sync(sync_a)
    );

    timing_gen u17 (
        .sysclk(sysclk), .poc_n(poc_n),
`ifdef TIMING_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .clk1(clk1_b), .clk2(clk2_b), .subcycle(sub_b),
        .a12(st_b[0]), .a22(st_b[1]), .a32(st_b[2]), .m12(st_b[3]),
        .m22(st_b[4]), .x12(st_b[5]), .x22(st_b[6]), .x32(st_b[7]),
        .m12_m22_clk1_m11_m12(comp_b), .sync(sync_b)
    );

    // Expected outputs t cycles after the first edge (t<0: still in reset/idle)
    function automatic logic [14:0] model(int pl, int t);
        int slot, sub, p;
        logic [7:0] st;
        if (t < 0) return '0;
        slot = (t / pl) % 4;
        sub  = (t / (4 * pl)) % 8;
        p    = t % (32 * pl);
        st   = (t >= 2 * pl) ? 8'd1 << (((t - 2 * pl) / (4 * pl)) % 8) : 8'd0;
        return {slot == 0, slot == 2, 3'(sub), st, (slot == 0) || (p >= 14 * pl && p < 22 * pl), sub == 7};
    endfunction

    task automatic chk(string tag, logic [14:0] got, logic [14:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic run(int n, bit both);
        repeat (n) begin
            @(posedge sysclk);
            k++;
            @(negedge sysclk);
            chk("pl2", v2, model(2, k - 1));
            if (both) begin
                chk("pl17", v17, model(17, k - 1));
                chk("overlap", {14'd0, clk1_b & clk2_b}, 15'd0);
            end
        end
    endtask

    task automatic reset_pulse(int n);
        #($urandom_range(1, 8));
        poc_n = 1'b0;
        #1;
        chk("rst_pl2", v2, 15'd0);
        chk("rst_pl17", v17, 15'd0);
        repeat (n) @(negedge sysclk);
        poc_n = 1'b1;
        k = 0;
    endtask

`ifdef TIMING_SINGLE_STEP_EN
    task automatic stall_chk(int n, string tag);
        repeat (n) begin
            @(posedge sysclk);
            @(negedge sysclk);
            chk(tag, v2, model(2, 63));
        end
    endtask
`endif

    initial begin
        repeat (2) @(negedge sysclk);
        chk("reset_pl2", v2, model(2, -1));
        chk("reset_pl17", v17, model(17, -1));
        poc_n = 1'b1;
        run(5440, 1'b1);
        reset_pulse(3);
        run(37, 1'b1);
        reset_pulse(3);
        run(40, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(1, 700), 1'b1);
            reset_pulse($urandom_range(1, 5));
        end
        run(100, 1'b1);
`ifdef TIMING_SINGLE_STEP_EN
        step_mode = 1'b1;
        reset_pulse(2);
        run(64, 1'b0);
        stall_chk(100, "stall");
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sysclk);
            @(negedge sysclk);
            if (i == 0) step = 1'b0;
            chk("step_latency", v2, model(2, 63));
        end
        k = 0;
        run(64, 1'b0);
        stall_chk(20, "restall");
        step_mode = 1'b0;
        k = 0;
        run(70, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
